wb_port_scheduler: RTL and testbench
====================================

# wb_port_scheduler

Write-back port scheduler for the vector processor. It sits after the MEM/WB pipeline register and shares one narrow register-file write port between vector and scalar write-backs. Each 32-bit vector result is split into per-element beats, scalar writes are interleaved with priority, and a stall is raised back to the pipeline while queued work exceeds one beat.

## Interface

Parameters:
- LANES, 4, elements per vector word; must be a power of 2; ELEM_W = $clog2(LANES).
- LANE_W, 8, bits per element and scalar data width; vector word width is LANES*LANE_W (32).
- DIR_W, 3, register address width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- sel_wb_in  in  1  vector source select: 1 selects MEM_in, 0 selects DATA_in.
- reg_wrv_in  in  1  instruction writes a vector register.
- reg_wrs_in  in  1  instruction writes a scalar register.
- MEM_in  in  LANES*LANE_W  memory result word.
- DATA_in  in  LANES*LANE_W  ALU result word.
- dir_dest_in  in  DIR_W  destination register address (vector and scalar).
- data_wrs_in  in  LANE_W  scalar write data.
- stall  out  1  pipeline hold; inputs are not accepted while high.
- busy  out  1  queued work W != 0.
- wr_en  out  1  write strobe for this cycle.
- wr_vec  out  1  1 targets the vector file, 0 targets the scalar file.
- wr_dir  out  DIR_W  write address.
- wr_elem  out  ELEM_W  element index (vector writes only; 0 on scalar writes).
- wr_data  out  LANE_W  write data.

## Operation

- State: vector word buffer, vector address, beat counter `beat` (0..LANES-1), `vec_act`, `sc_pend` with scalar data and address.
- Work count: W = sc_pend + (vec_act ? LANES - beat : 0).
- stall = (W > 1). It is a function of registered state only, with no combinational path from inputs.
- Accept: at a posedge with stall = 0, the input set is captured.
  - If reg_wrv_in: latch word = sel_wb_in ? MEM_in : DATA_in and dir_dest_in; beat <= 0; vec_act <= 1.
  - If reg_wrs_in: latch data_wrs_in and dir_dest_in; sc_pend <= 1.
  - If neither is set: no state change (bubble).
- Issue: on every posedge, one write is selected from the pre-edge state.
  - Priority 1, sc_pend: wr_en=1, wr_vec=0, wr_dir=scalar address, wr_elem=0, wr_data=scalar data; clear sc_pend.
  - Priority 2, vec_act: wr_en=1, wr_vec=1, wr_dir=vector address, wr_elem=beat, wr_data=word[beat*LANE_W +: LANE_W].
    - beat increments.
    - On beat = LANES-1, vec_act <= 0.
  - Otherwise: wr_en=0; wr_vec, wr_dir, wr_elem and wr_data hold their last values.
- Simultaneous accept and last issue on the same edge: the issue consumes the old state and the accept loads the new state. No beat is lost or duplicated.
- Instruction with both reg_wrv_in and reg_wrs_in: the scalar write goes first, then LANES vector beats.
- Element order: ascending, element 0 = word[LANE_W-1:0].

## Timing

- Reset (async, rst=1): sc_pend=0, vec_act=0, beat=0. All outputs are 0, including stall=0 and busy=0.
- Reset mid-sequence: remaining beats and any pending scalar write are discarded. No wr_en is asserted after rst falls until a new instruction is accepted.
- Latency: instruction accepted at edge N; its first write is visible on wr_* after edge N+1.
- Vector only: beats at edges N+1..N+LANES.
  - stall is high after edges N..N+LANES-2.
  - The next instruction is accepted at edge N+LANES.
- Scalar only: W never exceeds 1, so stall stays 0 and throughput is one write per cycle.
- Scalar + vector: writes at edges N+1..N+LANES+1; next accept at edge N+LANES+1.
- Port utilization with back-to-back vector instructions is 100%, with no idle cycle between words.
- Upstream must hold its inputs stable while stall=1; inputs sampled while stall=1 are ignored.

## Test plan

- Reset: assert rst mid-vector sequence at beat 2 -> outputs 0 immediately, no further wr_en, stall=0.
- Single vector write: sel_wb_in=1, MEM_in=0xA1B2C3D4, dir_dest_in=5.
  - Beats: wr_data 0xD4, 0xC3, 0xB2, 0xA1 with wr_elem 0..3, wr_dir=5, wr_vec=1.
  - stall is high for 3 cycles.
- Source select: sel_wb_in=0, DATA_in=0x11223344, MEM_in=0xFFFFFFFF -> beats 0x44, 0x33, 0x22, 0x11.
- Back-to-back scalars: 3 consecutive scalar instructions (data 0x10, 0x20, 0x30; dirs 1, 2, 3).
  - One write per cycle, wr_vec=0, stall never asserted.
- Mixed: reg_wrv_in=reg_wrs_in=1, data_wrs_in=0x7E, DATA_in=0x01020304, dir 6.
  - Scalar 0x7E first, then vector beats 0x04, 0x03, 0x02, 0x01.
  - Next accept exactly 5 edges after the first.
- Streaming: 4 back-to-back vector instructions -> 16 consecutive wr_en cycles, with the last beat of each word immediately followed by elem 0 of the next.

Source files
------------

// File: rtl/wb_port_scheduler.sv
// Write-back port scheduler: shares one narrow register-file write port between
// per-element vector beats and priority scalar writes, stalling upstream while backlog > 1.
module wb_port_scheduler #(
   parameter int LANES  = 4,
   parameter int LANE_W = 8,
   parameter int DIR_W  = 3,
   localparam int ELEM_W = $clog2(LANES),
   localparam int WORD_W = LANES * LANE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel_wb_in,
   input  logic              reg_wrv_in,
   input  logic              reg_wrs_in,
   input  logic [WORD_W-1:0] MEM_in,
   input  logic [WORD_W-1:0] DATA_in,
   input  logic [DIR_W-1:0]  dir_dest_in,
   input  logic [LANE_W-1:0] data_wrs_in,
   output logic              stall,
   output logic              busy,
   output logic              wr_en,
   output logic              wr_vec,
   output logic [DIR_W-1:0]  wr_dir,
   output logic [ELEM_W-1:0] wr_elem,
   output logic [LANE_W-1:0] wr_data
);

   localparam int                CNT_W     = ELEM_W + 2;
   localparam logic [ELEM_W-1:0] LAST_BEAT = ELEM_W'(LANES - 1);

   typedef enum logic [1:0] {
      ISSUE_NONE,
      ISSUE_SCALAR,
      ISSUE_VECTOR
   } issue_e;

   logic [WORD_W-1:0] word_q;
   logic [DIR_W-1:0]  vdir_q;
   logic [ELEM_W-1:0] beat_q;
   logic              vec_act_q;
   logic              sc_pend_q;
   logic [LANE_W-1:0] sdata_q;
   logic [DIR_W-1:0]  sdir_q;

   logic [CNT_W-1:0]  work;
   logic [LANE_W-1:0] lane_data;
   logic              accept;
   issue_e            issue;

   // Backlog in write-port cycles; stall depends on registered state only.
   always_comb begin
      // NOTE: every combinationally driven variable gets a default first, so no path can infer a latch.
      work = CNT_W'(sc_pend_q);
      if (vec_act_q)
         work = work + CNT_W'(LANES) - CNT_W'(beat_q);
   end

   assign stall     = (work > CNT_W'(1));
   assign busy      = (work != '0);
   assign accept    = !stall;
   assign lane_data = word_q[beat_q*LANE_W +: LANE_W];

   // Scalar writes always win the port over vector beats.
   always_comb begin
      issue = ISSUE_NONE;
      if (sc_pend_q)
         issue = ISSUE_SCALAR;
      else if (vec_act_q)
         issue = ISSUE_VECTOR;
   end

   // Issue consumes the pre-edge state; a same-edge accept then overrides what it loads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the data buffers are reset too, so nothing undefined can reach the port after reset.
         word_q    <= '0;
         vdir_q    <= '0;
         beat_q    <= '0;
         vec_act_q <= 1'b0;
         sc_pend_q <= 1'b0;
         sdata_q   <= '0;
         sdir_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every read in this block on pre-edge values,
         // and let the later accept assignments win over the issue updates.
         case (issue)
            ISSUE_SCALAR: sc_pend_q <= 1'b0;
            ISSUE_VECTOR: begin
               beat_q <= beat_q + ELEM_W'(1);
               if (beat_q == LAST_BEAT)
                  vec_act_q <= 1'b0;
            end
            default: ;
         endcase

         if (accept && reg_wrv_in) begin
            word_q    <= sel_wb_in ? MEM_in : DATA_in;
            vdir_q    <= dir_dest_in;
            beat_q    <= '0;
            vec_act_q <= 1'b1;
         end
         if (accept && reg_wrs_in) begin
            sdata_q   <= data_wrs_in;
            sdir_q    <= dir_dest_in;
            sc_pend_q <= 1'b1;
         end
      end
   end

   // Registered write port; address/data hold their last values on idle cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en   <= 1'b0;
         wr_vec  <= 1'b0;
         wr_dir  <= '0;
         wr_elem <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= 1'b0;
         case (issue)
            ISSUE_SCALAR: begin
               wr_en   <= 1'b1;
               wr_vec  <= 1'b0;
               wr_dir  <= sdir_q;
               wr_elem <= '0;
               wr_data <= sdata_q;
            end
            ISSUE_VECTOR: begin
               wr_en   <= 1'b1;
               wr_vec  <= 1'b1;
               wr_dir  <= vdir_q;
               wr_elem <= beat_q;
               wr_data <= lane_data;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Directed testbench for wb_port_scheduler: hand-computed beats, stall windows,
// scalar priority, streaming and mid-sequence reset.
module tb_wb_port_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel_wb_in;
   logic        reg_wrv_in;
   logic        reg_wrs_in;
   logic [31:0] MEM_in;
   logic [31:0] DATA_in;
   logic [2:0]  dir_dest_in;
   logic [7:0]  data_wrs_in;
   logic        stall;
   logic        busy;
   logic        wr_en;
   logic        wr_vec;
   logic [2:0]  wr_dir;
   logic [1:0]  wr_elem;
   logic [7:0]  wr_data;

   int n_tests = 0;
   int n_fail  = 0;

   wb_port_scheduler #(.LANES(4), .LANE_W(8), .DIR_W(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .sel_wb_in   (sel_wb_in),
      .reg_wrv_in  (reg_wrv_in),
      .reg_wrs_in  (reg_wrs_in),
      .MEM_in      (MEM_in),
      .DATA_in     (DATA_in),
      .dir_dest_in (dir_dest_in),
      .data_wrs_in (data_wrs_in),
      .stall       (stall),
      .busy        (busy),
      .wr_en       (wr_en),
      .wr_vec      (wr_vec),
      .wr_dir      (wr_dir),
      .wr_elem     (wr_elem),
      .wr_data     (wr_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge and sample 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit wrv, input bit wrs, input bit sel, input logic [31:0] mem,
                        input logic [31:0] data, input logic [2:0] dir, input logic [7:0] sdat);
      reg_wrv_in  = wrv;
      reg_wrs_in  = wrs;
      sel_wb_in   = sel;
      MEM_in      = mem;
      DATA_in     = data;
      dir_dest_in = dir;
      data_wrs_in = sdat;
   endtask

   task automatic idle();
      drive(0, 0, 0, 32'h0, 32'h0, 3'd0, 8'h00);
   endtask

   task automatic check_write(input string tag, input bit vec, input logic [2:0] dir,
                              input logic [1:0] elem, input logic [7:0] data);
      check({tag, ".en"},   32'(wr_en),   32'd1);
      check({tag, ".vec"},  32'(wr_vec),  32'(vec));
      check({tag, ".dir"},  32'(wr_dir),  32'(dir));
      check({tag, ".elem"}, 32'(wr_elem), 32'(elem));
      check({tag, ".data"}, 32'(wr_data), 32'(data));
   endtask

   // One vector instruction, inputs held while stalled; exp holds the hand-computed bytes,
   // element 0 in the low byte.
   task automatic vec_test(input string nm, input bit sel, input logic [31:0] mem,
                           input logic [31:0] data, input logic [2:0] dir, input logic [31:0] exp);
      drive(1, 0, sel, mem, data, dir, 8'h00);
      step();
      check({nm, ".stall_acc"}, 32'(stall), 32'd1);
      check({nm, ".en_acc"},    32'(wr_en), 32'd0);
      for (int i = 0; i < 4; i++) begin
         if (!stall) idle();
         step();
         check_write($sformatf("%s.b%0d", nm, i), 1'b1, dir, 2'(i), exp[i*8 +: 8]);
         check($sformatf("%s.stall%0d", nm, i), 32'(stall), (i < 2) ? 32'd1 : 32'd0);
      end
      idle();
      step();
      check({nm, ".en_end"},   32'(wr_en),   32'd0);
      check({nm, ".busy_end"}, 32'(busy),    32'd0);
      check({nm, ".hold"},     32'(wr_data), 32'(exp[31:24]));
   endtask

   initial begin
      logic [31:0] words [4];
      int          next_w;

      rst = 1'b1;
      idle();
      #12;
      check("rst.stall", 32'(stall),   32'd0);
      check("rst.busy",  32'(busy),    32'd0);
      check("rst.en",    32'(wr_en),   32'd0);
      check("rst.vec",   32'(wr_vec),  32'd0);
      check("rst.dir",   32'(wr_dir),  32'd0);
      check("rst.elem",  32'(wr_elem), 32'd0);
      check("rst.data",  32'(wr_data), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step();
      check("idle.en", 32'(wr_en), 32'd0);

      vec_test("vec_mem", 1'b1, 32'hA1B2C3D4, 32'h0, 3'd5, 32'hA1B2C3D4);
      vec_test("vec_src", 1'b0, 32'hFFFFFFFF, 32'h11223344, 3'd2, 32'h11223344);

      // Back-to-back scalars: one write per cycle, never stalled.
      drive(0, 1, 0, 32'h0, 32'h0, 3'd1, 8'h10);
      step();
      check("sc.stall0", 32'(stall), 32'd0);
      check("sc.busy0",  32'(busy),  32'd1);
      check("sc.en0",    32'(wr_en), 32'd0);
      drive(0, 1, 0, 32'h0, 32'h0, 3'd2, 8'h20);
      step();
      check_write("sc.w1", 1'b0, 3'd1, 2'd0, 8'h10);
      check("sc.stall1", 32'(stall), 32'd0);
      drive(0, 1, 0, 32'h0, 32'h0, 3'd3, 8'h30);
      step();
      check_write("sc.w2", 1'b0, 3'd2, 2'd0, 8'h20);
      check("sc.stall2", 32'(stall), 32'd0);
      idle();
      step();
      check_write("sc.w3", 1'b0, 3'd3, 2'd0, 8'h30);
      check("sc.stall3", 32'(stall), 32'd0);
      step();
      check("sc.en_end", 32'(wr_en), 32'd0);

      // Mixed: scalar first, then four beats; next accept exactly five edges later.
      drive(1, 1, 0, 32'hFFFFFFFF, 32'h01020304, 3'd6, 8'h7E);
      step();
      check("mix.stall_acc", 32'(stall), 32'd1);
      for (int i = 0; i < 5; i++) begin
         if (!stall) drive(0, 1, 0, 32'h0, 32'h0, 3'd7, 8'h55);
         check($sformatf("mix.hold%0d", i), 32'(stall), (i < 4) ? 32'd1 : 32'd0);
         step();
         if (i == 0)
            check_write("mix.sc", 1'b0, 3'd6, 2'd0, 8'h7E);
         else
            check_write($sformatf("mix.b%0d", i - 1), 1'b1, 3'd6, 2'(i - 1), 8'(5 - i));
      end
      check("mix.busy_next", 32'(busy),  32'd1);
      check("mix.stall_nx",  32'(stall), 32'd0);
      idle();
      step();
      check_write("mix.next", 1'b0, 3'd7, 2'd0, 8'h55);
      step();
      check("mix.en_end", 32'(wr_en), 32'd0);

      // Streaming: four words whose bytes are 0..15 in issue order, dirs 0..3.
      words[0] = 32'h03020100;
      words[1] = 32'h07060504;
      words[2] = 32'h0B0A0908;
      words[3] = 32'h0F0E0D0C;
      drive(1, 0, 1, words[0], 32'h0, 3'd0, 8'h00);
      next_w = 1;
      step();
      for (int k = 0; k < 16; k++) begin
         if (!stall) begin
            if (next_w < 4) begin
               drive(1, 0, 1, words[next_w], 32'h0, 3'(next_w), 8'h00);
               next_w++;
            end else begin
               idle();
            end
         end
         step();
         check_write($sformatf("str.k%0d", k), 1'b1, 3'(k / 4), 2'(k % 4), 8'(k));
      end
      idle();
      step();
      check("str.en_end", 32'(wr_en), 32'd0);
      check("str.busy",   32'(busy),  32'd0);

      // Reset mid-vector: two beats issued, beat counter at 2.
      drive(1, 0, 1, 32'hA1B2C3D4, 32'h0, 3'd5, 8'h00);
      step();
      idle();
      step();
      step();
      check("rmid.beat1", 32'(wr_data), 32'hC3);
      rst = 1'b1;
      #1;
      check("rmid.en",    32'(wr_en),   32'd0);
      check("rmid.data",  32'(wr_data), 32'd0);
      check("rmid.dir",   32'(wr_dir),  32'd0);
      check("rmid.vec",   32'(wr_vec),  32'd0);
      check("rmid.stall", 32'(stall),   32'd0);
      check("rmid.busy",  32'(busy),    32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         check($sformatf("rpost.en%0d", i), 32'(wr_en), 32'd0);
         check($sformatf("rpost.busy%0d", i), 32'(busy), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
